// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map,
// vector address defaults and small helper functions.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] INTC_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_PENDING = 2'd1;
    localparam logic [1:0] INTC_STATUS  = 2'd2;
    localparam logic [1:0] INTC_EOI     = 2'd3;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0010;

    // Index width that stays legal for a single source.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [3:0]  idx);
        return base + stride * {28'b0, idx};
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-set-bit priority encoder; bit 0 has the highest priority.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/intc_top.sv
// Memory-mapped interrupt controller: edge-detects source lines into pending,
// raises irq for the highest-priority enabled source and holds until EOI.
module intc_top
    import intc_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         A,
    input  logic               WE,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic               irq,
    output logic [31:0]        irq_addr,
    input  logic               irq_ack
);

    localparam int IDX_W = idx_width(NUM_SRC);

    state_t              state, state_next;
    logic [NUM_SRC-1:0]  src_q, pending, pending_next, enable;
    logic [NUM_SRC-1:0]  rise, w1c, ack_clr;
    logic [IDX_W-1:0]    active_idx, enc_idx;
    logic                enc_valid, take;
    logic                enable_wr, pending_wr, eoi_wr;
    logic                unused_wd;

    assign enable_wr  = WE && (A == INTC_ENABLE);
    assign pending_wr = WE && (A == INTC_PENDING);
    assign eoi_wr     = WE && (A == INTC_EOI);
    assign unused_wd  = &{1'b0, WD[31:NUM_SRC]};

    assign rise = src & ~src_q;
    assign w1c  = pending_wr ? WD[NUM_SRC-1:0] : '0;

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (pending & enable),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Acknowledge clears only the bit being serviced.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (state == REQ && irq_ack && active_idx == IDX_W'(i)) ack_clr[i] = 1'b1;
        end
    end

    // A rise in the same cycle as a clear re-sets the bit.
    assign pending_next = (pending & ~w1c & ~ack_clr) | rise;

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_next = REQ;
                    take       = 1'b1;
                end
            end
            REQ:     if (irq_ack) state_next = SERVICE;
            SERVICE: if (eoi_wr)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            pending    <= '0;
            enable     <= '0;
            active_idx <= '0;
            irq        <= 1'b0;
            irq_addr   <= '0;
        end else begin
            src_q   <= src;
            pending <= pending_next;
            irq     <= (state_next == REQ);
            if (enable_wr) enable <= WD[NUM_SRC-1:0];
            if (take) begin
                active_idx <= enc_idx;
                irq_addr   <= vec_addr(VEC_BASE, VEC_STRIDE, 4'(enc_idx));
            end
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            INTC_ENABLE:  RD[NUM_SRC-1:0] = enable;
            INTC_PENDING: RD[NUM_SRC-1:0] = pending;
            INTC_STATUS: begin
                RD[3:2] = state;
                RD[7:4] = 4'(active_idx);
            end
            INTC_EOI:     RD = VEC_BASE;
            default:      RD = '0;
        endcase
    end

endmodule

// File: tb/tb_intc_top.sv
// Self-checking bench for intc_top: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_intc_top;

    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] STRIDE = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src = '0;
    logic [1:0]  A = '0;
    logic        WE = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        irq;
    logic [31:0] irq_addr;
    logic        irq_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    intc_top #(
        .NUM_SRC    (4),
        .VEC_BASE   (BASE),
        .VEC_STRIDE (STRIDE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .A        (A),
        .WE       (WE),
        .WD       (WD),
        .RD       (RD),
        .irq      (irq),
        .irq_addr (irq_addr),
        .irq_ack  (irq_ack)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in service.
    bit [3:0]    m_srcq, m_pend, m_en;
    int          m_phase, m_idx;
    bit          m_irq;
    logic [31:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_srcq = '0; m_pend = '0; m_en = '0;
        m_phase = 0; m_idx = 0; m_irq = 0; m_addr = '0;
    endfunction

    // Advances the model across one clock edge using the inputs currently driven.
    function automatic void model_step();
        bit [3:0] rise = src & ~m_srcq;
        bit [3:0] np   = m_pend;
        bit [3:0] ready = m_pend & m_en;
        int nphase = m_phase;
        if (WE && A == 2'd1) np = np & ~WD[3:0];
        if (m_phase == 0 && ready != 0) begin
            for (int i = 3; i >= 0; i--) if (ready[i]) m_idx = i;
            m_addr = BASE + 32'(m_idx) * STRIDE;
            nphase = 1;
        end else if (m_phase == 1 && irq_ack) begin
            np[m_idx] = 1'b0;
            nphase = 2;
        end else if (m_phase == 2 && WE && A == 2'd3) begin
            nphase = 0;
        end
        np = np | rise;
        if (WE && A == 2'd0) m_en = WD[3:0];
        m_pend  = np;
        m_srcq  = src;
        m_phase = nphase;
        m_irq   = (nphase == 1);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_en};
            2'd1:    return {28'b0, m_pend};
            2'd2:    return 32'((m_idx << 4) | (m_phase << 2));
            default: return BASE;
        endcase
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        check("irq_addr", irq_addr, m_addr);
        check("rd", RD, exp_rd(A));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        A = a; WD = d; WE = 1'b1;
        cycle();
        WE = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        A = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src = '0; WE = 1'b0; irq_ack = 1'b0;
        #1;
        check("rst_irq_async", {31'b0, irq}, 32'd0);
        check("rst_addr_async", irq_addr, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int n_req;
    bit prev_irq;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-run and register defaults.
        wr(2'd0, 32'h5);
        src = 4'h1; cycle(); src = 4'h0; cycle();
        do_reset();
        rd_check("rst_enable", 2'd0, 32'h0);
        rd_check("rst_pending", 2'd1, 32'h0);
        rd_check("rst_status", 2'd2, 32'h0);
        rd_check("eoi_read", 2'd3, 32'h100);
        wr(2'd0, 32'hF);
        rd_check("enable_rw", 2'd0, 32'hF);

        // Single source.
        wr(2'd0, 32'h4);
        src = 4'h4; cycle(); src = 4'h0; cycle();
        check("single_irq", {31'b0, irq}, 32'd1);
        check("single_addr", irq_addr, 32'h120);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        check("single_ack_irq", {31'b0, irq}, 32'd0);
        rd_check("single_pending", 2'd1, 32'h0);
        rd_check("single_status", 2'd2, 32'h28);
        wr(2'd3, 32'h0);
        rd_check("single_eoi_status", 2'd2, 32'h20);

        // Priority between simultaneous rises.
        wr(2'd0, 32'hF);
        src = 4'hA; cycle(); src = 4'h0; cycle();
        check("prio_addr", irq_addr, 32'h110);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        wr(2'd3, 32'h0);
        cycle();
        check("prio_second_irq", {31'b0, irq}, 32'd1);
        check("prio_second_addr", irq_addr, 32'h130);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        wr(2'd3, 32'h0);

        // Masked pending becomes a request once enabled.
        wr(2'd0, 32'h0);
        src = 4'h1; cycle(); src = 4'h0; cycle(); cycle();
        check("masked_irq", {31'b0, irq}, 32'd0);
        rd_check("masked_pending", 2'd1, 32'h1);
        wr(2'd0, 32'h1);
        cycle();
        check("masked_late_irq", {31'b0, irq}, 32'd1);
        check("masked_late_addr", irq_addr, 32'h100);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        wr(2'd3, 32'h0);

        // W1C coincident with a rise: the set wins.
        wr(2'd0, 32'h0);
        src = 4'h1; A = 2'd1; WD = 32'h1; WE = 1'b1;
        cycle();
        WE = 1'b0; src = 4'h0;
        rd_check("w1c_vs_rise", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        rd_check("w1c_clear", 2'd1, 32'h0);

        // A source held high for 10 cycles requests only once.
        wr(2'd0, 32'h1);
        n_req = 0; prev_irq = 1'b0;
        src = 4'h1;
        for (int i = 0; i < 10; i++) begin
            irq_ack = (m_phase == 1);
            WE = (m_phase == 2); A = 2'd3; WD = '0;
            cycle();
            if (irq && !prev_irq) n_req++;
            prev_irq = irq;
        end
        irq_ack = 1'b0; WE = 1'b0; src = 4'h0;
        check("held_once", 32'(n_req), 32'd1);

        // Acknowledge in IDLE has no effect.
        A = 2'd2;
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        check("ack_idle_state", {30'b0, RD[3:2]}, 32'd0);
        check("ack_idle_irq", {31'b0, irq}, 32'd0);

        // Reset while in service, then a normal request.
        wr(2'd0, 32'h2);
        src = 4'h2; cycle(); src = 4'h0; cycle();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        rd_check("svc_state", 2'd2, 32'h18);
        do_reset();
        rd_check("svc_rst_status", 2'd2, 32'h0);
        rd_check("svc_rst_pending", 2'd1, 32'h0);
        wr(2'd0, 32'h2);
        src = 4'h2; cycle(); src = 4'h0; cycle();
        check("post_rst_irq", {31'b0, irq}, 32'd1);
        check("post_rst_addr", irq_addr, 32'h110);
        // Reset while requesting drops irq immediately.
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            src     = 4'($urandom_range(0, 15));
            A       = 2'($urandom_range(0, 3));
            WD      = $urandom;
            WE      = ($urandom_range(0, 3) == 0);
            irq_ack = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            cycle();
        end
        WE = 1'b0; irq_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
